// File: rtl/mvm_requant_out.sv
// Requantizing output stage for the 8x8 matrix-vector multiplier: rounds, clamps and
// buffers 24-bit results in a small FIFO, re-emitting them as a tagged 12-bit stream.
module mvm_requant_out #(
  parameter int IN_WIDTH  = 24,
  parameter int OUT_WIDTH = 12,
  parameter int SHIFT     = 6,
  parameter int RELU      = 1,
  parameter int DEPTH     = 8,
  parameter int VEC_LEN   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic [IN_WIDTH-1:0]  input_data,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic [OUT_WIDTH-1:0] output_data,
  output logic                 output_first,
  output logic                 sat_flag
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int SUM_W = IN_WIDTH + 1;

  localparam logic [CNT_W-1:0]        FULL_CNT = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(VEC_LEN - 1);
  localparam logic signed [SUM_W-1:0] ROUND    = SUM_W'(1) << (SHIFT - 1);
  localparam logic signed [SUM_W-1:0] Q_MAX    = SUM_W'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [SUM_W-1:0] Q_MIN    = ~Q_MAX;

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [IDX_W-1:0] idx;

  // Each entry holds {first tag, requantized element}.
  logic [OUT_WIDTH:0] mem [DEPTH];

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] q;
  logic [OUT_WIDTH-1:0]    q_out;
  logic                    q_sat;
  logic                    push;
  logic                    pop;

  // Rounding shift, optional ReLU, then saturation; ReLU alone is not a saturation event.
  always_comb begin
    sum   = $signed({input_data[IN_WIDTH-1], input_data}) + ROUND;
    q     = sum >>> SHIFT;
    q_sat = 1'b0;
    if (RELU != 0 && q[SUM_W-1]) begin
      q = '0;
    end
    if (q > Q_MAX) begin
      q_out = Q_MAX[OUT_WIDTH-1:0];
      q_sat = 1'b1;
    end else if (q < Q_MIN) begin
      q_out = Q_MIN[OUT_WIDTH-1:0];
      q_sat = 1'b1;
    end else begin
      q_out = q[OUT_WIDTH-1:0];
    end
  end

  // Ready depends only on stored occupancy (and reset), never on output_ready.
  assign input_ready  = reset && (count != FULL_CNT);
  assign output_valid = (count != '0);
  assign push         = input_valid && input_ready;
  assign pop          = output_valid && output_ready;

  assign output_data  = output_valid ? mem[rd_ptr][OUT_WIDTH-1:0] : '0;
  assign output_first = output_valid && mem[rd_ptr][OUT_WIDTH];

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      idx      <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        idx    <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        if (q_sat) begin
          sat_flag <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // NOTE: the storage array has no reset; stale entries are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {(idx == '0), q_out};
    end
  end

endmodule

// File: tb/tb_mvm_requant_out.sv
// Randomized self-checking bench for mvm_requant_out: two instances (ReLU on/off) share
// stimulus and are scored against an arithmetic reference model and an expected-output queue.
module tb_mvm_requant_out;

  localparam int IN_W    = 24;
  localparam int OUT_W   = 12;
  localparam int SHIFT   = 6;
  localparam int DEPTH   = 8;
  localparam int VEC_LEN = 8;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [IN_W-1:0]  in_data   = '0;
  logic             in_ready1, in_ready0;
  logic             out_valid1, out_valid0;
  logic             out_first1, out_first0;
  logic             sat1, sat0;
  logic [OUT_W-1:0] out_data1, out_data0;

  always #5 clk = ~clk;

  mvm_requant_out #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SHIFT(SHIFT), .RELU(1),
                    .DEPTH(DEPTH), .VEC_LEN(VEC_LEN)) dut (
    .clk(clk), .reset(rst_n), .input_valid(in_valid), .input_ready(in_ready1),
    .input_data(in_data), .output_valid(out_valid1), .output_ready(out_ready),
    .output_data(out_data1), .output_first(out_first1), .sat_flag(sat1)
  );

  mvm_requant_out #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SHIFT(SHIFT), .RELU(0),
                    .DEPTH(DEPTH), .VEC_LEN(VEC_LEN)) dut_norelu (
    .clk(clk), .reset(rst_n), .input_valid(in_valid), .input_ready(in_ready0),
    .input_data(in_data), .output_valid(out_valid0), .output_ready(out_ready),
    .output_data(out_data0), .output_first(out_first0), .sat_flag(sat0)
  );

  typedef struct {
    int d1;
    int d0;
    bit first;
  } exp_t;

  exp_t exp_q[$];
  int   pushes;
  bit   exp_sat1, exp_sat0;
  int   log_d1[$];
  int   log_d0[$];
  bit   log_first[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stall;
  int   st_d1, st_d0;
  bit   st_f;
  bit   done;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: floor((x + 2^(SHIFT-1)) / 2^SHIFT), optional ReLU, clamp to OUT_W signed.
  function automatic void ref_q(input int x, input bit relu, output int q, output bit sat);
    longint s, f, den;
    den = longint'(2 ** SHIFT);
    s   = longint'(x) + longint'(2 ** (SHIFT - 1));
    f   = s / den;
    if ((s % den) != 0 && s < 0) f = f - 1;
    if (relu && f < 0) f = 0;
    sat = 1'b0;
    if (f > longint'(2 ** (OUT_W - 1) - 1)) begin
      f = longint'(2 ** (OUT_W - 1) - 1);
      sat = 1'b1;
    end else if (f < -longint'(2 ** (OUT_W - 1))) begin
      f = -longint'(2 ** (OUT_W - 1));
      sat = 1'b1;
    end
    q = int'(f);
  endfunction

  // Scoreboard: compare at the falling edge, then apply the handshakes the next rising edge commits.
  always @(negedge clk) begin
    bit   ev, er, s1, s0;
    int   q1, q0, x;
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      pushes   = 0;
      exp_sat1 = 1'b0;
      exp_sat0 = 1'b0;
      stall    = 1'b0;
      check("rst_input_ready", in_ready1, 0);
      check("rst_output_valid", out_valid1, 0);
      check("rst_output_first", out_first1, 0);
      check("rst_output_data", int'(out_data1), 0);
      check("rst_sat_flag", sat1, 0);
    end else begin
      ev = exp_q.size() > 0;
      er = exp_q.size() < DEPTH;
      check("input_ready", in_ready1, er);
      check("input_ready_norelu", in_ready0, er);
      check("output_valid", out_valid1, ev);
      check("output_valid_norelu", out_valid0, ev);
      check("sat_flag", sat1, exp_sat1);
      check("sat_flag_norelu", sat0, exp_sat0);
      if (ev) begin
        e = exp_q[0];
        check("output_data", int'($signed(out_data1)), e.d1);
        check("output_data_norelu", int'($signed(out_data0)), e.d0);
        check("output_first", out_first1, e.first);
        check("output_first_norelu", out_first0, e.first);
      end
      if (stall) begin
        check("stall_data", int'($signed(out_data1)), st_d1);
        check("stall_data_norelu", int'($signed(out_data0)), st_d0);
        check("stall_first", out_first1, st_f);
      end
      stall = ev && !out_ready;
      st_d1 = int'($signed(out_data1));
      st_d0 = int'($signed(out_data0));
      st_f  = out_first1;
      if (ev && out_ready) begin
        void'(exp_q.pop_front());
        log_d1.push_back(int'($signed(out_data1)));
        log_d0.push_back(int'($signed(out_data0)));
        log_first.push_back(out_first1);
      end
      if (in_valid && er) begin
        x = int'($signed(in_data));
        ref_q(x, 1'b1, q1, s1);
        ref_q(x, 1'b0, q0, s0);
        e.d1    = q1;
        e.d0    = q0;
        e.first = (pushes % VEC_LEN) == 0;
        exp_q.push_back(e);
        pushes++;
        exp_sat1 = exp_sat1 | s1;
        exp_sat0 = exp_sat0 | s0;
      end
    end
  end

  task automatic push(input int x);
    bit ok;
    in_valid = 1'b1;
    in_data  = IN_W'(x);
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int c = 0; c < 1000 && exp_q.size() > 0; c++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    int base, nf, x;
    #2;
    check("reset_input_ready", in_ready1, 0);
    check("reset_output_valid", out_valid1, 0);
    check("reset_output_data", int'(out_data1), 0);
    check("reset_sat_flag", sat1, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("ready_after_reset", in_ready1, 1);

    // Single push: 1000 -> 16, tagged first, one cycle latency.
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(1000);
    check("t1_valid", out_valid1, 1);
    check("t1_data", int'($signed(out_data1)), 16);
    check("t1_first", out_first1, 1);
    check("t1_sat", sat1, 0);
    drain();

    // Rounding, ReLU and saturation corners.
    apply_reset();
    out_ready = 1'b1;
    base = log_d1.size();
    push(-100);
    push(200000);
    push(-200000);
    drain();
    check("t2_relu_a", log_d1[base], 0);
    check("t2_relu_b", log_d1[base+1], 2047);
    check("t2_relu_c", log_d1[base+2], 0);
    check("t2_norelu_a", log_d0[base], -2);
    check("t2_norelu_b", log_d0[base+1], 2047);
    check("t2_norelu_c", log_d0[base+2], -2048);
    check("t2_sat_relu", sat1, 1);
    check("t2_sat_norelu", sat0, 1);

    // Fill to full with the consumer stalled, hold the 9th upstream, then drain.
    apply_reset();
    out_ready = 1'b0;
    base = log_d1.size();
    for (int i = 0; i < 8; i++) push(i * 1000 + 7);
    check("t3_full_ready", in_ready1, 0);
    fork
      push(9 * 1000 + 7);
      begin
        repeat (3) begin
          @(posedge clk);
          #1 check("t3_hold_9th", in_ready1, 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("t3_count", log_d1.size() - base, 9);
    check("t3_first0", log_first[base], 1);
    check("t3_first1", log_first[base+1], 0);
    check("t3_first8", log_first[base+8], 1);

    // Streaming at one element per cycle.
    apply_reset();
    out_ready = 1'b1;
    base = log_d1.size();
    for (int i = 0; i < 16; i++) begin
      push((i + 1) * 100 - 800);
      check("t4_valid", out_valid1, 1);
      check("t4_ready", in_ready1, 1);
    end
    drain();
    check("t4_count", log_d1.size() - base, 16);
    nf = 0;
    for (int i = 0; i < 16; i++) nf += int'(log_first[base+i]);
    check("t4_first_total", nf, 2);
    check("t4_first0", log_first[base], 1);
    check("t4_first8", log_first[base+8], 1);

    // Random traffic with random backpressure.
    apply_reset();
    base = log_d1.size();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          if ($urandom % 4 == 0) begin
            repeat ($urandom_range(1, 2)) begin
              @(posedge clk);
              #1;
            end
          end
          if ($urandom % 6 == 0) x = int'($urandom) >>> 8;
          else x = int'($urandom_range(0, 1 << 18)) - (1 << 17);
          push(x);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom % 2);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("t5_count", log_d1.size() - base, 64);

    // Asynchronous reset with five entries queued.
    apply_reset();
    out_ready = 1'b0;
    push(200000);
    for (int i = 1; i < 5; i++) push(i * 50);
    check("t6_sat_before", sat1, 1);
    check("t6_valid_before", out_valid1, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_valid_drop", out_valid1, 0);
    check("t6_sat_drop", sat1, 0);
    check("t6_ready_in_reset", in_ready1, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("t6_ready_after", in_ready1, 1);
    out_ready = 1'b1;
    push(64);
    check("t6_first", out_first1, 1);
    check("t6_data", int'($signed(out_data1)), 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mvm_requant_out.md
Name: mvm_requant_out

Overview:
- Downstream stage of the 8x8 matrix-vector multiplier.
- Consumes the multiplier's 24-bit signed results over a valid/ready handshake.
- Requantizes each result to 12-bit signed: rounding arithmetic right shift, optional ReLU, saturation.
- Buffers results in a small FIFO and re-emits them as a 12-bit stream, with a first-element tag per output vector, so they can drive the next multiplier's 12-bit input_data port.

Parameters:
IN_WIDTH, 24, input result width (signed)
OUT_WIDTH, 12, output element width (signed)
SHIFT, 6, arithmetic right-shift amount; legal range 1..IN_WIDTH-1
RELU, 1, 1 = clamp negative results to 0; 0 = pass signed
DEPTH, 8, FIFO entries; power of two, >= 2
VEC_LEN, 8, elements per output vector; sets output_first spacing

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-low reset
input_valid  in  1  upstream result valid
input_ready  out  1  block can accept a result this cycle
input_data  in  IN_WIDTH  signed result from multiplier
output_valid  out  1  output_data/output_first valid
output_ready  in  1  downstream accepts this cycle
output_data  out  OUT_WIDTH  requantized signed element
output_first  out  1  high when output_data is element 0 of a vector
sat_flag  out  1  sticky: some accepted result saturated

Behaviour:
- Reset (reset==0, asynchronous):
  - Clears FIFO count, read pointer, write pointer, input element index and sat_flag.
  - input_ready=0, output_valid=0, output_first=0, output_data=0.
- After reset deasserts: input_ready=1 from the first cycle.
- Accept (push):
  - A push occurs on a posedge when input_valid && input_ready.
  - input_ready = (count < DEPTH), driven from registered state only; it has no combinational path from output_ready.
- Emit (pop):
  - A pop occurs on a posedge when output_valid && output_ready.
  - output_valid = (count > 0).
  - output_data and output_first come from the FIFO head entry.
- Latency:
  - A result pushed at edge k is visible on the output in the cycle after edge k, provided the FIFO was empty.
  - There is no combinational input-to-output bypass.
- Simultaneous push and pop:
  - Allowed whenever count is between 1 and DEPTH-1; count is unchanged.
  - When full, input_ready=0, so no push can occur even if a pop happens that cycle.
  - When empty, only a push can occur.
- Pointers: wrap modulo DEPTH.
- Requantization is combinational on input_data and is applied at push time:
  - sum = sign-extended input_data (IN_WIDTH+1 bits) + 2^(SHIFT-1).
  - q = sum >>> SHIFT (arithmetic; round half toward +inf).
  - If RELU==1 and q<0, then q=0.
  - Saturate q to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. The ReLU clamp alone does not count as saturation.
- Element index:
  - A counter increments on every push and wraps VEC_LEN-1 -> 0.
  - The stored output_first bit = (index==0) at push time.
- sat_flag:
  - Set on any push whose q was clamped by the saturation step.
  - Cleared only by reset.
- Output data must not change while output_valid && !output_ready; the handshake is stable.
- Reset mid-stream: all buffered entries are discarded and the element index restarts at 0.

Test Plan:
- Single push of 1000 (SHIFT=6, RELU=1), output_ready=1 -> next cycle output_valid=1, output_data=16, output_first=1, sat_flag=0.
- Pushes of -100, then 200000, then -200000:
  - RELU=1 -> outputs 0, 2047, 0; sat_flag=1.
  - RELU=0 -> outputs -2, 2047, -2048; sat_flag=1.
- output_ready=0, push 9 values continuously:
  - input_ready drops after the 8th accept; the 9th value is held upstream.
  - Then output_ready=1 -> all 9 values drain in order.
  - output_first is high on the 1st and 9th outputs.
- Continuous input_valid=1 and output_ready=1 for 16 values:
  - One output per cycle after the first.
  - count stays at 1.
  - output_first pulses on elements 0 and 8.
- Toggle output_ready randomly for 64 values and compare against a reference model -> no loss, no duplication, order preserved, data stable while stalled.
- Assert reset with 5 entries queued, mid-cycle -> output_valid and sat_flag drop immediately; after release, input_ready=1 and the next push is tagged output_first=1.
